// File: rtl/opc_intc.sv
// ---------------------------------------------------------------------------
// opc_intc -- vectored, priority interrupt controller for the OPC CPU family.
//
// Widens the CPU's int_b input to NUM_IRQ channels. Each channel can be edge
// or level triggered, can be masked, and has nested in-service tracking. The
// ISR reads VECTOR to acknowledge and writes ISR (EOI) to retire.
// Channel 0 has the highest priority.
//
// Ports
//   i_clk    clock, all state changes on the rising edge
//   i_reset  synchronous active-high reset (ignores i_clken)
//   i_clken  clock enable; state frozen while low
//   i_irq    asynchronous interrupt requests, one per channel
//   i_sel    register access select (qualified by CPU vio)
//   i_rnw    1 = read, 0 = write
//   i_addr   register index: 0 PEND, 1 MASK, 2 VECTOR, 3 ISR
//   i_din    write data
//   o_dout   combinational read data, zero when not reading
//   o_irq_b  registered, active-low interrupt request to the CPU
// ---------------------------------------------------------------------------
module opc_intc #(
    parameter int          NUM_IRQ    = 8,
    parameter logic [15:0] EDGE_MASK  = 16'hFFFF,
    parameter logic [15:0] VEC_BASE   = 16'h0100,
    parameter int          VEC_STRIDE = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clken,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic               i_sel,
    input  logic               i_rnw,
    input  logic [1:0]         i_addr,
    input  logic [15:0]        i_din,
    output logic [15:0]        o_dout,
    output logic               o_irq_b
);

    localparam logic [NUM_IRQ-1:0] EDGE   = EDGE_MASK[NUM_IRQ-1:0];
    localparam logic [31:0]        SPUR32 = 32'(VEC_BASE) + 32'(NUM_IRQ * VEC_STRIDE);
    localparam logic [15:0]        SPUR   = SPUR32[15:0];

    localparam logic [1:0] A_PEND = 2'd0;
    localparam logic [1:0] A_MASK = 2'd1;
    localparam logic [1:0] A_VEC  = 2'd2;
    localparam logic [1:0] A_ISR  = 2'd3;

    // Synchroniser chain plus history flop
    logic [NUM_IRQ-1:0] r_s1, r_s2, r_s3;
    // Stored pending bits; only edge channels are ever set here
    logic [NUM_IRQ-1:0] r_pend_e;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_isr;
    logic               r_irq_b;

    logic [NUM_IRQ-1:0] w_pend;
    logic [NUM_IRQ-1:0] w_act;
    logic [NUM_IRQ-1:0] w_edge;
    logic [4:0]         w_top;
    logic               w_top_v;
    logic [4:0]         w_cur;
    logic               w_cur_v;
    logic               w_req;
    logic [15:0]        w_vec;
    logic [NUM_IRQ-1:0] w_top_oh;
    logic [NUM_IRQ-1:0] w_cur_oh;
    logic               w_acc;
    logic               w_ack;
    logic               w_wr_pend;
    logic               w_wr_mask;
    logic               w_eoi;
    logic [NUM_IRQ-1:0] w_w1c;
    logic [NUM_IRQ-1:0] w_pend_e_nxt;
    logic [NUM_IRQ-1:0] w_isr_nxt;
    logic               w_unused_din;

    // Upper write-data bits have no destination when NUM_IRQ < 16
    assign w_unused_din = ^i_din;

    // Level channels are pending while the synchronised line is high and the
    // channel is not already in service; they hold no stored state.
    assign w_pend = (r_pend_e & EDGE) | (r_s2 & ~EDGE & ~r_isr);
    assign w_act  = w_pend & r_mask;

    // The edge event is s2 & !s3 as seen after this edge. Using the values
    // that will be loaded into s2/s3 lets pend set on the same edge that s2
    // rises, giving the 2-edge pend / 3-edge irq_b latency.
    assign w_edge = r_s1 & ~r_s2 & EDGE;

    // Lowest-index priority encoders for the active request and in-service
    always_comb begin
        w_top   = '0;
        w_top_v = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_act[i]) begin
                w_top   = 5'(i);
                w_top_v = 1'b1;
            end
        end
    end

    always_comb begin
        w_cur   = '0;
        w_cur_v = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (r_isr[i]) begin
                w_cur   = 5'(i);
                w_cur_v = 1'b1;
            end
        end
    end

    // Only strictly higher priority than the current ISR may nest
    assign w_req    = w_top_v && (!w_cur_v || (w_top < w_cur));
    assign w_vec    = VEC_BASE + 16'(w_top) * 16'(VEC_STRIDE);
    assign w_top_oh = NUM_IRQ'(1) << w_top;
    assign w_cur_oh = NUM_IRQ'(1) << w_cur;

    // Bus strobes; side effects only on an enabled, selected edge
    assign w_acc     = i_clken & i_sel;
    assign w_ack     = w_acc &  i_rnw & (i_addr == A_VEC) & w_req;
    assign w_wr_pend = w_acc & ~i_rnw & (i_addr == A_PEND);
    assign w_wr_mask = w_acc & ~i_rnw & (i_addr == A_MASK);
    assign w_eoi     = w_acc & ~i_rnw & (i_addr == A_ISR) & w_cur_v;

    assign w_w1c = w_wr_pend ? i_din[NUM_IRQ-1:0] : '0;

    // Clears first, then new edge events, so a set on the same edge wins
    always_comb begin
        w_pend_e_nxt = r_pend_e & ~w_w1c;
        if (w_ack) begin
            w_pend_e_nxt = w_pend_e_nxt & ~w_top_oh;
        end
        w_pend_e_nxt = (w_pend_e_nxt | w_edge) & EDGE;
    end

    // A single bus access cannot both acknowledge and retire
    always_comb begin
        w_isr_nxt = r_isr;
        if (w_ack) begin
            w_isr_nxt = r_isr | w_top_oh;
        end else if (w_eoi) begin
            w_isr_nxt = r_isr & ~w_cur_oh;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_s3     <= '0;
            r_pend_e <= '0;
            r_mask   <= '0;
            r_isr    <= '0;
            r_irq_b  <= 1'b1;
        end else if (i_clken) begin
            r_s1     <= i_irq;
            r_s2     <= r_s1;
            r_s3     <= r_s2;
            r_pend_e <= w_pend_e_nxt;
            if (w_wr_mask) begin
                r_mask <= i_din[NUM_IRQ-1:0];
            end
            r_isr    <= w_isr_nxt;
            // Registered from pre-edge state: ack/EOI shows up one edge later
            r_irq_b  <= ~w_req;
        end
    end

    assign o_irq_b = r_irq_b;

    // The VECTOR value is computed from the same pre-edge state that drives
    // the acknowledge update, so the returned vector always matches it.
    always_comb begin
        o_dout = 16'h0000;
        if (i_sel && i_rnw) begin
            case (i_addr)
                A_PEND:  o_dout = 16'(w_pend);
                A_MASK:  o_dout = 16'(r_mask);
                A_VEC:   o_dout = w_req ? w_vec : SPUR;
                A_ISR:   o_dout = 16'(r_isr);
                default: o_dout = 16'h0000;
            endcase
        end
    end

    // r_s3 is the edge-history flop; the edge term reads its next value (r_s2)
    logic w_unused_s3;
    assign w_unused_s3 = ^r_s3;

endmodule

// File: tb/tb_opc_intc.sv
module tb_opc_intc;

    localparam int          N   = 8;
    localparam logic [15:0] EM  = 16'hFFF7;   // channel 3 is level triggered
    localparam logic [7:0]  EDG = 8'hF7;

    logic        clk;
    logic        reset;
    logic        clken;
    logic [7:0]  irq;
    logic        sel;
    logic        rnw;
    logic [1:0]  addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        irq_b;

    opc_intc #(
        .NUM_IRQ   (N),
        .EDGE_MASK (EM),
        .VEC_BASE  (16'h0100),
        .VEC_STRIDE(2)
    ) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .i_clken(clken),
        .i_irq  (irq),
        .i_sel  (sel),
        .i_rnw  (rnw),
        .i_addr (addr),
        .i_din  (din),
        .o_dout (dout),
        .o_irq_b(irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] last_dout;
    logic        last_irqb;

    // Behavioural model: smp0/smp1 are the irq samples taken on the last two
    // enabled edges; a channel is "seen" high once it has been sampled twice.
    logic [7:0] smp0, smp1;
    logic [7:0] m_pe, m_mask, m_isr;
    logic       m_irqb;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 99;
    endfunction

    function automatic logic [7:0] m_pend();
        return (m_pe & EDG) | (smp1 & ~EDG & ~m_isr);
    endfunction

    function automatic bit m_req();
        logic [7:0] a;
        a = m_pend() & m_mask;
        return (a != 0) && (lowest(a) < lowest(m_isr));
    endfunction

    function automatic logic [15:0] m_dout();
        if (!(sel && rnw)) return 16'h0000;
        case (addr)
            2'd0: return {8'h00, m_pend()};
            2'd1: return {8'h00, m_mask};
            2'd2: return m_req() ? 16'(16'h0100 + 2 * lowest(m_pend() & m_mask)) : 16'h0110;
            default: return {8'h00, m_isr};
        endcase
    endfunction

    task automatic model_step();
        int t, c;
        bit rq, ack;
        logic [7:0] pe;
        if (reset) begin
            smp0 = 0; smp1 = 0; m_pe = 0; m_mask = 0; m_isr = 0; m_irqb = 1'b1;
        end else if (clken) begin
            rq  = m_req();
            t   = lowest(m_pend() & m_mask);
            c   = lowest(m_isr);
            ack = sel && rnw && addr == 2'd2 && rq;
            pe  = m_pe;
            if (sel && !rnw && addr == 2'd0) pe = pe & ~din[7:0];
            if (ack) pe = pe & ~8'(1 << t);
            pe = (pe | (smp0 & ~smp1)) & EDG;   // a new rise beats any clear
            m_pe = pe;
            if (sel && !rnw && addr == 2'd1) m_mask = din[7:0];
            if (ack) m_isr = m_isr | 8'(1 << t);
            if (sel && !rnw && addr == 2'd3 && c != 99) m_isr = m_isr & ~8'(1 << c);
            smp1 = smp0;
            smp0 = irq;
            m_irqb = !rq;
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: compare away from the edge, then advance the model on the edge
    task automatic tick();
        #2;
        last_dout = dout;
        last_irqb = irq_b;
        chk("dout", dout, m_dout());
        chk("irq_b", {15'b0, irq_b}, {15'b0, m_irqb});
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        sel = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd(input logic [1:0] a);
        sel = 1; rnw = 1; addr = a;
        tick();
        sel = 0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        sel = 1; rnw = 0; addr = a; din = d;
        tick();
        sel = 0;
    endtask

    initial begin
        reset = 1; clken = 1; irq = 0; sel = 0; rnw = 1; addr = 0; din = 0;
        repeat (2) @(posedge clk);
        model_step();
        #1;
        reset = 0;

        // Reset state
        rd(0); chk("rst_pend", last_dout, 16'h0000);
        rd(1); chk("rst_mask", last_dout, 16'h0000);
        rd(3); chk("rst_isr",  last_dout, 16'h0000);
        chk("rst_irqb", {15'b0, last_irqb}, 16'h0001);

        // Masked channels latch pend but never request
        irq = 8'h21; idle(4); irq = 0; idle(2);
        rd(0); chk("masked_pend", last_dout, 16'h0021);
        chk("masked_irqb", {15'b0, last_irqb}, 16'h0001);
        wr(0, 16'h00FF);

        // Edge channel 5: 3-edge latency, ack, EOI
        wr(1, 16'h00FF);
        irq = 8'h20; tick(); tick(); tick();
        chk("lat_pre3", {15'b0, last_irqb}, 16'h0001);
        irq = 0;
        rd(2); chk("lat_post3", {15'b0, last_irqb}, 16'h0000);
        chk("vec5", last_dout, 16'h010A);
        rd(3); chk("isr5", last_dout, 16'h0020);
        tick(); chk("irqb_after_ack", {15'b0, last_irqb}, 16'h0001);
        wr(3, 16'h0000);
        rd(3); chk("isr_eoi", last_dout, 16'h0000);

        // Nesting 5 -> 2, with 7 waiting
        irq = 8'h20; tick(); irq = 0; idle(3); rd(2);
        irq = 8'h04; tick(); irq = 0; idle(3);
        rd(2); chk("vec2", last_dout, 16'h0104);
        rd(3); chk("isr_nest", last_dout, 16'h0024);
        irq = 8'h80; tick(); irq = 0; idle(4);
        chk("ch7_wait", {15'b0, last_irqb}, 16'h0001);
        wr(3, 16'h0000);
        rd(3); chk("eoi_bit2", last_dout, 16'h0020);
        idle(2); chk("ch7_wait2", {15'b0, last_irqb}, 16'h0001);
        wr(3, 16'h0000); idle(2);
        chk("ch7_req", {15'b0, last_irqb}, 16'h0000);
        rd(2); chk("vec7", last_dout, 16'h010E);
        wr(3, 16'h0000); idle(2);

        // Spurious vector
        rd(2); chk("spurious", last_dout, 16'h0110);
        rd(3); chk("spur_isr", last_dout, 16'h0000);

        // Level channel 3
        wr(1, 16'h0008);
        irq = 8'h08; idle(3);
        rd(2); chk("vec3", last_dout, 16'h0106);
        idle(2); wr(3, 16'h0000); idle(2);
        chk("level_repend", {15'b0, last_irqb}, 16'h0000);
        rd(2); irq = 0; idle(3); wr(3, 16'h0000); idle(3);
        chk("level_drop", {15'b0, last_irqb}, 16'h0001);

        // W1C on the same edge as a new edge event: set wins
        wr(1, 16'h0000);
        irq = 8'h10; idle(4); irq = 0; idle(2);
        rd(0); chk("pend4", last_dout, 16'h0010);
        irq = 8'h10; tick(); wr(0, 16'h0010);
        rd(0); chk("w1c_vs_set", last_dout, 16'h0010);
        irq = 0; wr(0, 16'h0010);
        rd(0); chk("w1c", last_dout, 16'h0000);

        // Reset mid-ISR
        wr(1, 16'h00FF);
        irq = 8'h20; tick(); irq = 0; idle(3); rd(2);
        irq = 8'h04; tick(); irq = 0; idle(3); rd(2);
        rd(3); chk("isr_pre_rst", last_dout, 16'h0024);
        reset = 1; tick(); reset = 0;
        rd(3); chk("isr_post_rst", last_dout, 16'h0000);
        chk("irqb_post_rst", {15'b0, last_irqb}, 16'h0001);
        rd(1); chk("mask_post_rst", last_dout, 16'h0000);

        // clken low freezes the latency count
        wr(1, 16'h00FF);
        irq = 8'h02; tick();
        clken = 0; idle(5); clken = 1;
        tick(); tick();
        chk("frz_pre3", {15'b0, last_irqb}, 16'h0001);
        tick();
        chk("frz_post3", {15'b0, last_irqb}, 16'h0000);
        irq = 0;
        rd(2); chk("vec1", last_dout, 16'h0102);
        wr(3, 16'h0000); idle(2);

        // Randomised traffic against the model
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 399) == 0);
            clken = ($urandom_range(0, 7) != 0);
            irq   = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            sel   = ($urandom_range(0, 2) == 0);
            rnw   = ($urandom_range(0, 2) != 0);
            addr  = 2'($urandom);
            din   = 16'($urandom);
            tick();
        end
        reset = 0; clken = 1; sel = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
